// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan sweep checker.
package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DM_TYPE1 = 1'b0;
  localparam logic DM_TYPE2 = 1'b1;

endpackage

// File: rtl/demorgan_eval.sv
// Combinational evaluation of both sides of the selected De Morgan law.
module demorgan_eval
  import demorgan_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] x,
  input  logic            mode,
  output logic            lhs,
  output logic            rhs
);

  // Type 1 compares a NOR against an AND of inverted inputs; type 2 compares a NAND against an OR of inverted inputs.
  always_comb begin
    lhs = ~(|x);
    rhs = &(~x);
    if (mode == DM_TYPE2) begin
      lhs = ~(&x);
      rhs = |(~x);
    end
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Self-running sweep over every input vector, comparing both sides of a De Morgan law.
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic            fault_en,
  input  logic [N_IN-1:0] fault_vec,
  output logic            busy,
  output logic            out_valid,
  output logic [N_IN-1:0] vec_out,
  output logic            lhs_out,
  output logic            rhs_out,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld,
  output logic            done,
  output logic            pass
);

  localparam logic [N_IN-1:0] CNT_ONE = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   ERR_ONE = {{N_IN{1'b0}}, 1'b1};

  state_t          state;
  logic [N_IN-1:0] cnt;
  logic            mode_q;
  logic            fault_en_q;
  logic [N_IN-1:0] fault_vec_q;
  logic            lhs;
  logic            rhs;
  logic            rhs_f;

  demorgan_eval #(.N_IN(N_IN)) u_eval (
    .x    (cnt),
    .mode (mode_q),
    .lhs  (lhs),
    .rhs  (rhs)
  );

  assign rhs_f = rhs ^ (fault_en_q && (cnt == fault_vec_q));

  // The counter is the vector being issued; its result is registered one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      mode_q         <= 1'b0;
      fault_en_q     <= 1'b0;
      fault_vec_q    <= '0;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      vec_out        <= '0;
      lhs_out        <= 1'b0;
      rhs_out        <= 1'b0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            cnt            <= '0;
            mode_q         <= mode;
            fault_en_q     <= fault_en;
            fault_vec_q    <= fault_vec;
            err_cnt        <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
          end
        end
        RUN: begin
          out_valid <= 1'b1;
          vec_out   <= cnt;
          lhs_out   <= lhs;
          rhs_out   <= rhs_f;
          if (lhs != rhs_f) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (!first_fail_vld) begin
              first_fail_vec <= cnt;
              first_fail_vld <= 1'b1;
            end
          end
          // Park on all-ones so the sweep never wraps into a second pass.
          if (cnt == '1) begin
            state <= DRAIN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_cnt == '0);
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Directed bench for the De Morgan sweep checker at N_IN=4 and N_IN=2.
module tb_demorgan_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode, fault_en;
  logic [3:0] fault_vec;
  logic       busy, out_valid, lhs_out, rhs_out, first_fail_vld, done, pass;
  logic [3:0] vec_out, first_fail_vec;
  logic [4:0] err_cnt;

  logic       start2;
  logic [1:0] fault_vec2;
  logic       busy2, out_valid2, lhs_out2, rhs_out2, first_fail_vld2, done2, pass2;
  logic [1:0] vec_out2, first_fail_vec2;
  logic [2:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demorgan_sweep_checker #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fault_en(fault_en),
    .fault_vec(fault_vec), .busy(busy), .out_valid(out_valid), .vec_out(vec_out),
    .lhs_out(lhs_out), .rhs_out(rhs_out), .err_cnt(err_cnt),
    .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld),
    .done(done), .pass(pass)
  );

  demorgan_sweep_checker #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .fault_en(fault_en),
    .fault_vec(fault_vec2), .busy(busy2), .out_valid(out_valid2), .vec_out(vec_out2),
    .lhs_out(lhs_out2), .rhs_out(rhs_out2), .err_cnt(err_cnt2),
    .first_fail_vec(first_fail_vec2), .first_fail_vld(first_fail_vld2),
    .done(done2), .pass(pass2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle4(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, " vec_out"}, 32'(vec_out), 0);
    checkOutput({tag, " lhs_out"}, 32'(lhs_out), 0);
    checkOutput({tag, " rhs_out"}, 32'(rhs_out), 0);
    checkOutput({tag, " err_cnt"}, 32'(err_cnt), 0);
    checkOutput({tag, " first_fail_vec"}, 32'(first_fail_vec), 0);
    checkOutput({tag, " first_fail_vld"}, 32'(first_fail_vld), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " pass"}, 32'(pass), 0);
  endtask

  // Full 16-vector sweep; inputs are scrambled after start to show they were latched.
  task automatic applyStimulus(input logic m, input logic fe, input logic [3:0] fv, input int glitch_k);
    int  exp_err = 0;
    int  exp_first = 0;
    logic exp_lhs, exp_rhs;
    mode = m; fault_en = fe; fault_vec = fv; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; fault_en = ~fe; fault_vec = ~fv;
    checkOutput("t1 busy", 32'(busy), 1);
    checkOutput("t1 out_valid", 32'(out_valid), 0);
    checkOutput("t1 err_cnt", 32'(err_cnt), 0);
    checkOutput("t1 pass", 32'(pass), 0);
    checkOutput("t1 first_fail_vld", 32'(first_fail_vld), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      start = 1'b0;
      exp_lhs = m ? (k != 15) : (k == 0);
      exp_rhs = exp_lhs ^ (fe && (k == int'(fv)));
      if (exp_lhs != exp_rhs) begin
        if (exp_err == 0) exp_first = k;
        exp_err++;
      end
      checkOutput("run out_valid", 32'(out_valid), 1);
      checkOutput("run vec_out", 32'(vec_out), 32'(k));
      checkOutput("run lhs_out", 32'(lhs_out), 32'(exp_lhs));
      checkOutput("run rhs_out", 32'(rhs_out), 32'(exp_rhs));
      checkOutput("run err_cnt", 32'(err_cnt), 32'(exp_err));
      checkOutput("run busy", 32'(busy), 1);
      checkOutput("run done", 32'(done), 0);
      if (k == glitch_k) start = 1'b1;
    end
    tick();
    checkOutput("end done", 32'(done), 1);
    checkOutput("end pass", 32'(pass), 32'(exp_err == 0));
    checkOutput("end err_cnt", 32'(err_cnt), 32'(exp_err));
    checkOutput("end busy", 32'(busy), 0);
    checkOutput("end out_valid", 32'(out_valid), 0);
    checkOutput("end first_fail_vld", 32'(first_fail_vld), 32'(exp_err != 0));
    if (exp_err != 0) checkOutput("end first_fail_vec", 32'(first_fail_vec), 32'(exp_first));
    tick();
    checkOutput("post1 done", 32'(done), 0);
    checkOutput("post1 pass", 32'(pass), 32'(exp_err == 0));
    tick();
    checkOutput("post2 done", 32'(done), 0);
    checkOutput("post2 err_cnt", 32'(err_cnt), 32'(exp_err));
    checkOutput("post2 busy", 32'(busy), 0);
    mode = 1'b0; fault_en = 1'b0; fault_vec = 4'h0;
  endtask

  // Four-vector sweep on the N_IN=2 instance.
  task automatic applyStimulus2(input logic m, input logic fe, input logic [1:0] fv);
    int   exp_err = 0;
    logic exp_lhs, exp_rhs;
    mode = m; fault_en = fe; fault_vec2 = fv; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_lhs = m ? (k != 3) : (k == 0);
      exp_rhs = exp_lhs ^ (fe && (k == int'(fv)));
      if (exp_lhs != exp_rhs) exp_err++;
      checkOutput("n2 out_valid", 32'(out_valid2), 1);
      checkOutput("n2 vec_out", 32'(vec_out2), 32'(k));
      checkOutput("n2 lhs_out", 32'(lhs_out2), 32'(exp_lhs));
      checkOutput("n2 rhs_out", 32'(rhs_out2), 32'(exp_rhs));
      checkOutput("n2 done early", 32'(done2), 0);
    end
    tick();
    checkOutput("n2 done", 32'(done2), 1);
    checkOutput("n2 err_cnt", 32'(err_cnt2), 32'(exp_err));
    checkOutput("n2 pass", 32'(pass2), 32'(exp_err == 0));
    checkOutput("n2 first_fail_vld", 32'(first_fail_vld2), 32'(exp_err != 0));
    if (exp_err != 0) checkOutput("n2 first_fail_vec", 32'(first_fail_vec2), 32'(fv));
    tick();
    checkOutput("n2 post done", 32'(done2), 0);
    mode = 1'b0; fault_en = 1'b0; fault_vec2 = 2'b00;
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; mode = 1'b0; fault_en = 1'b0; fault_vec = 4'h0;
    start2 = 1'b0; fault_vec2 = 2'b00;
    tick();
    tick();
    checkIdle4("reset");
    checkOutput("reset n2 done", 32'(done2), 0);
    rst = 1'b0;
    tick();

    $display("[TB] mode=1 clean sweep");
    applyStimulus(1'b1, 1'b0, 4'h0, -1);
    $display("[TB] mode=0 clean sweep");
    applyStimulus(1'b0, 1'b0, 4'h0, -1);
    $display("[TB] mode=1 fault at 0xA");
    applyStimulus(1'b1, 1'b1, 4'hA, -1);
    $display("[TB] start pulsed again at T+5");
    applyStimulus(1'b1, 1'b0, 4'h0, 3);

    $display("[TB] reset mid-sweep at vec 7");
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("midrst vec_out", 32'(vec_out), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle4("midrst");
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy || out_valid) done_seen++;
    end
    checkOutput("midrst abandoned", 32'(done_seen), 0);

    $display("[TB] rst and start together");
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    checkOutput("rststart busy", 32'(busy), 0);
    checkOutput("rststart out_valid", 32'(out_valid), 0);

    $display("[TB] fresh sweep after reset");
    applyStimulus(1'b1, 1'b0, 4'h0, -1);

    $display("[TB] N_IN=2 sweeps");
    applyStimulus2(1'b1, 1'b0, 2'b00);
    applyStimulus2(1'b0, 1'b1, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
